// File: rtl/cube_move_scheduler.sv
// cube_move_scheduler: queues manual/undo moves and sequences them and scramble bursts onto the move engine
module cube_move_scheduler #(
    parameter int SCRAMBLE_LEN = 30,
    parameter int HIST_DEPTH   = 64,
    parameter int CNT_MAX      = 999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       manual_req,
    input  logic [2:0] manual_face,
    input  logic [1:0] manual_rot,
    input  logic       undo_req,
    input  logic       scramble_req,
    input  logic [2:0] rand_face,
    input  logic [1:0] rand_rot,
    input  logic       solved_in,
    output logic [2:0] eng_face,
    output logic [2:0] eng_rot,
    output logic       cube_load,
    output logic       cube_init,
    output logic       hist_push,
    output logic       hist_pop,
    output logic [5:0] hist_ptr,
    output logic [9:0] move_count,
    output logic       solved,
    output logic       busy,
    output logic       drop,
    output logic [2:0] state
);
    typedef enum logic [2:0] {INIT, IDLE, SCRAMBLE, EXEC, VERIFY, SOLVED} state_t;
    localparam logic [5:0] HMAX  = 6'(HIST_DEPTH - 1);
    localparam logic [9:0] CMAX  = 10'(CNT_MAX);
    localparam logic [5:0] SLAST = 6'(SCRAMBLE_LEN - 1);
    state_t cur, nxt;
    logic [5:0] q [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] q_cnt;
    logic       op_undo;
    logic [2:0] op_face;
    logic [1:0] op_rot;
    logic [5:0] scr_cnt;
    logic       drop_q;
    logic       req, push, pop, reject, scr_start, flush, mv, un;
    assign req       = manual_req | undo_req;
    assign pop       = cur == IDLE && !scramble_req && q_cnt != 3'd0;
    assign push      = req && (cur inside {IDLE, SCRAMBLE, EXEC, VERIFY}) && (q_cnt != 3'd4 || pop);
    assign reject    = (manual_req && undo_req) || (req && !push) || (cur == IDLE && scramble_req && q_cnt != 3'd0);
    assign scr_start = nxt == SCRAMBLE && cur != SCRAMBLE;
    assign flush     = nxt == SOLVED && cur != SOLVED;
    assign mv        = cur == EXEC && !op_undo && op_rot != 2'd0;
    assign un        = cur == EXEC && op_undo && hist_ptr != 6'd0;
    // Engine command and strobes, decoded from the registered state and op register
    always_comb begin
        eng_face  = cur == SCRAMBLE ? rand_face : op_face;
        eng_rot   = cur == SCRAMBLE ? (rand_rot == 2'd0 ? 3'd1 : rand_rot == 2'd1 ? 3'd3 : rand_rot == 2'd2 ? 3'd2 : 3'd0)
                                    : (op_rot == 2'd1 ? 3'd1 : op_rot == 2'd2 ? 3'd3 : op_rot == 2'd3 ? 3'd2 : 3'd0);
        cube_load = cur == SCRAMBLE || mv;
        cube_init = cur == INIT;
        hist_push = mv && hist_ptr < HMAX;
        hist_pop  = un;
        busy      = cur != IDLE;
        drop      = drop_q || (cur == EXEC && op_undo && hist_ptr == 6'd0);
        state     = cur;
    end
    // Next-state selection
    always_comb begin
        nxt = cur;
        case (cur)
            INIT:     nxt = IDLE;
            IDLE:     nxt = scramble_req ? (q_cnt == 3'd0 ? SCRAMBLE : IDLE) : (q_cnt != 3'd0 ? EXEC : IDLE);
            SCRAMBLE: nxt = scr_cnt == SLAST ? IDLE : SCRAMBLE;
            EXEC:     nxt = (mv || un) ? VERIFY : IDLE;
            VERIFY:   nxt = solved_in ? SOLVED : IDLE;
            SOLVED:   nxt = scramble_req ? SCRAMBLE : SOLVED;
            default:  nxt = INIT;
        endcase
    end
    // Queue payload; undo entries carry no face/rotation
    always_ff @(posedge clk) begin
        if (push) q[wr_ptr] <= {undo_req, undo_req ? 5'd0 : {manual_face, manual_rot}};
    end
    // State, queue pointers, op register, history pointer, counters and flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur        <= INIT;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            q_cnt      <= 3'd0;
            op_undo    <= 1'b0;
            op_face    <= 3'd0;
            op_rot     <= 2'd0;
            scr_cnt    <= 6'd0;
            hist_ptr   <= 6'd0;
            move_count <= 10'd0;
            solved     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            cur        <= nxt;
            wr_ptr     <= flush ? 2'd0 : wr_ptr + 2'(push);
            rd_ptr     <= flush ? 2'd0 : rd_ptr + 2'(pop);
            q_cnt      <= flush ? 3'd0 : q_cnt + 3'(push) - 3'(pop);
            if (pop) {op_undo, op_face, op_rot} <= q[rd_ptr];
            scr_cnt    <= cur == SCRAMBLE ? scr_cnt + 6'd1 : 6'd0;
            hist_ptr   <= scr_start ? 6'd0 : hist_push ? hist_ptr + 6'd1 : un ? hist_ptr - 6'd1 : hist_ptr;
            move_count <= scr_start ? 10'd0 : (mv && move_count != CMAX) ? move_count + 10'd1
                        : (un && move_count != 10'd0) ? move_count - 10'd1 : move_count;
            solved     <= scr_start ? 1'b0 : (cur == VERIFY && solved_in) ? 1'b1 : solved;
            drop_q     <= reject;
        end
    end
endmodule

// File: tb/tb_cube_move_scheduler.sv
// tb_cube_move_scheduler: directed scenario checks for the cube move scheduler
module tb_cube_move_scheduler;
    logic clk = 1'b0, rst = 1'b0;
    logic manual_req = 1'b0, undo_req = 1'b0, scramble_req = 1'b0, solved_in = 1'b0;
    logic [2:0] manual_face = 3'd0, rand_face = 3'd0;
    logic [1:0] manual_rot = 2'd0, rand_rot = 2'd0;
    logic [2:0] eng_face, eng_rot, state, b_eng_face, b_eng_rot, b_state;
    logic cube_load, cube_init, hist_push, hist_pop, solved, busy, drop;
    logic b_cube_load, b_cube_init, b_hist_push, b_hist_pop, b_solved, b_busy, b_drop;
    logic [5:0] hist_ptr, b_hist_ptr;
    logic [9:0] move_count, b_move_count;
    int checks = 0, errors = 0;
    logic [2:0] fv [3] = '{3'd4, 3'd5, 3'd0};
    logic [1:0] rv [3] = '{2'd3, 2'd1, 2'd2};
    logic [2:0] ev [3] = '{3'd0, 3'd3, 3'd2};

    always #5 clk = ~clk;

    cube_move_scheduler #(.SCRAMBLE_LEN(3)) dut (
        .clk(clk), .rst(rst), .manual_req(manual_req), .manual_face(manual_face), .manual_rot(manual_rot),
        .undo_req(undo_req), .scramble_req(scramble_req), .rand_face(rand_face), .rand_rot(rand_rot),
        .solved_in(solved_in), .eng_face(eng_face), .eng_rot(eng_rot), .cube_load(cube_load),
        .cube_init(cube_init), .hist_push(hist_push), .hist_pop(hist_pop), .hist_ptr(hist_ptr),
        .move_count(move_count), .solved(solved), .busy(busy), .drop(drop), .state(state));

    // Longer burst so that six requests fit inside one scramble
    cube_move_scheduler #(.SCRAMBLE_LEN(8)) dut8 (
        .clk(clk), .rst(rst), .manual_req(manual_req), .manual_face(manual_face), .manual_rot(manual_rot),
        .undo_req(undo_req), .scramble_req(scramble_req), .rand_face(rand_face), .rand_rot(rand_rot),
        .solved_in(solved_in), .eng_face(b_eng_face), .eng_rot(b_eng_rot), .cube_load(b_cube_load),
        .cube_init(b_cube_init), .hist_push(b_hist_push), .hist_pop(b_hist_pop), .hist_ptr(b_hist_ptr),
        .move_count(b_move_count), .solved(b_solved), .busy(b_busy), .drop(b_drop), .state(b_state));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        {manual_req, undo_req, scramble_req, solved_in} = 4'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({state, cube_init, busy, cube_load, hist_push, hist_pop, drop, solved, hist_ptr, move_count}
            !== {3'd0, 1'b1, 1'b1, 5'b0, 6'd0, 10'd0}) begin
            errors++;
            $display("FAIL reset_vals: state=%0d init=%b busy=%b load=%b drop=%b hp=%0d mc=%0d, want INIT/1/1/0/0/0/0",
                     state, cube_init, busy, cube_load, drop, hist_ptr, move_count);
        end
        @(negedge clk) rst = 1'b1;
        #1;
        checks++;
        if ({state, cube_init} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL init_cycle: state=%0d init=%b want 0/1", state, cube_init);
        end
        tick();
        checks++;
        if ({state, busy, cube_init, move_count, hist_ptr} !== {3'd1, 1'b0, 1'b0, 10'd0, 6'd0}) begin
            errors++;
            $display("FAIL idle_after_init: state=%0d busy=%b init=%b mc=%0d hp=%0d want 1/0/0/0/0",
                     state, busy, cube_init, move_count, hist_ptr);
        end
    endtask

    task automatic test_manual_undo;
        manual_req = 1'b1; manual_face = 3'd2; manual_rot = 2'b10;
        tick();
        manual_req = 1'b0;
        checks++;
        if ({state, cube_load} !== {3'd1, 1'b0}) begin
            errors++;
            $display("FAIL move_c1: state=%0d load=%b want 1/0", state, cube_load);
        end
        tick();
        checks++;
        if ({state, cube_load, eng_face, eng_rot, hist_push, hist_ptr} !== {3'd3, 1'b1, 3'd2, 3'd3, 1'b1, 6'd0}) begin
            errors++;
            $display("FAIL move_exec: state=%0d load=%b face=%0d rot=%0d push=%b hp=%0d want 3/1/2/3/1/0",
                     state, cube_load, eng_face, eng_rot, hist_push, hist_ptr);
        end
        tick();
        checks++;
        if ({state, hist_ptr, move_count} !== {3'd4, 6'd1, 10'd1}) begin
            errors++;
            $display("FAIL move_verify: state=%0d hp=%0d mc=%0d want 4/1/1", state, hist_ptr, move_count);
        end
        tick();
        undo_req = 1'b1;
        tick();
        undo_req = 1'b0;
        tick();
        checks++;
        if ({state, hist_pop, cube_load, hist_push} !== {3'd3, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL undo_exec: state=%0d pop=%b load=%b push=%b want 3/1/0/0", state, hist_pop, cube_load, hist_push);
        end
        tick();
        checks++;
        if ({state, hist_ptr, move_count} !== {3'd4, 6'd0, 10'd0}) begin
            errors++;
            $display("FAIL undo_verify: state=%0d hp=%0d mc=%0d want 4/0/0", state, hist_ptr, move_count);
        end
        tick();
        undo_req = 1'b1;
        tick();
        undo_req = 1'b0;
        tick();
        checks++;
        if ({state, drop, hist_pop} !== {3'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL undo_empty: state=%0d drop=%b pop=%b want 3/1/0", state, drop, hist_pop);
        end
        tick();
        checks++;
        if ({state, drop, hist_ptr} !== {3'd1, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL undo_empty_after: state=%0d drop=%b hp=%0d want 1/0/0", state, drop, hist_ptr);
        end
    endtask

    task automatic test_scramble;
        manual_req = 1'b1; manual_face = 3'd1; manual_rot = 2'b01;
        tick();
        manual_req = 1'b0;
        repeat (3) tick();
        checks++;
        if ({state, move_count, hist_ptr} !== {3'd1, 10'd1, 6'd1}) begin
            errors++;
            $display("FAIL pre_scramble: state=%0d mc=%0d hp=%0d want 1/1/1", state, move_count, hist_ptr);
        end
        scramble_req = 1'b1;
        tick();
        scramble_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_face = fv[i]; rand_rot = rv[i];
            #1;
            checks++;
            if ({state, cube_load, eng_face, eng_rot} !== {3'd2, 1'b1, fv[i], ev[i]}) begin
                errors++;
                $display("FAIL scramble_cycle%0d: state=%0d load=%b face=%0d rot=%0d want 2/1/%0d/%0d",
                         i, state, cube_load, eng_face, eng_rot, fv[i], ev[i]);
            end
            tick();
        end
        checks++;
        if ({state, cube_load, move_count, hist_ptr} !== {3'd1, 1'b0, 10'd0, 6'd0}) begin
            errors++;
            $display("FAIL scramble_end: state=%0d load=%b mc=%0d hp=%0d want 1/0/0/0", state, cube_load, move_count, hist_ptr);
        end
    endtask

    task automatic test_same_cycle;
        int nd = 0, np = 0, nl = 0;
        manual_req = 1'b1; manual_face = 3'd0; manual_rot = 2'b01;
        tick();
        manual_req = 1'b0;
        repeat (3) tick();
        manual_req = 1'b1; undo_req = 1'b1; manual_face = 3'd5; manual_rot = 2'b11;
        tick();
        manual_req = 1'b0; undo_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            nd += int'(drop); np += int'(hist_pop); nl += int'(cube_load);
            tick();
        end
        checks++;
        if (nd != 1 || np != 1 || nl != 0) begin
            errors++;
            $display("FAIL same_cycle_strobes: drops=%0d pops=%0d loads=%0d want 1/1/0", nd, np, nl);
        end
        checks++;
        if ({state, hist_ptr, move_count} !== {3'd1, 6'd0, 10'd0}) begin
            errors++;
            $display("FAIL same_cycle_end: state=%0d hp=%0d mc=%0d want 1/0/0", state, hist_ptr, move_count);
        end
    endtask

    task automatic test_queue_fill;
        logic [39:0] dmask = '0;
        logic [2:0] faces [4] = '{3'd7, 3'd7, 3'd7, 3'd7};
        int n = 0;
        do_reset();
        rand_face = 3'd1; rand_rot = 2'd0; manual_rot = 2'b01;
        for (int k = 0; k < 40; k++) begin
            scramble_req = k == 0;
            manual_req = k >= 1 && k <= 6;
            manual_face = 3'(k - 1);
            #1;
            dmask[k] = b_drop;
            if (b_state == 3'd3 && b_cube_load) begin
                if (n < 4) faces[n] = b_eng_face;
                n++;
            end
            if (k == 1) begin
                checks++;
                if ({b_state, b_cube_load, b_eng_rot} !== {3'd2, 1'b1, 3'd1}) begin
                    errors++;
                    $display("FAIL fill_scramble_rot0: state=%0d load=%b rot=%0d want 2/1/1", b_state, b_cube_load, b_eng_rot);
                end
            end
            tick();
        end
        {scramble_req, manual_req} = 2'b0;
        checks++;
        if (dmask !== ((40'd1 << 6) | (40'd1 << 7))) begin
            errors++;
            $display("FAIL fill_drops: mask=%h want %h", dmask, (40'd1 << 6) | (40'd1 << 7));
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL fill_exec_count: got %0d want 4", n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (faces[i] !== 3'(i)) begin
                errors++;
                $display("FAIL fill_order%0d: face=%0d want %0d", i, faces[i], i);
            end
        end
        checks++;
        if ({b_move_count, b_hist_ptr} !== {10'd4, 6'd4}) begin
            errors++;
            $display("FAIL fill_counts: mc=%0d hp=%0d want 4/4", b_move_count, b_hist_ptr);
        end
    endtask

    task automatic test_solved_and_reset;
        int nl = 0;
        do_reset();
        manual_req = 1'b1; manual_face = 3'd3; manual_rot = 2'b11;
        tick();
        manual_req = 1'b0;
        tick();
        checks++;
        if ({state, eng_face, eng_rot} !== {3'd3, 3'd3, 3'd2}) begin
            errors++;
            $display("FAIL double_exec: state=%0d face=%0d rot=%0d want 3/3/2", state, eng_face, eng_rot);
        end
        tick();
        solved_in = 1'b1;
        tick();
        solved_in = 1'b0;
        checks++;
        if ({state, solved, busy} !== {3'd5, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL solved_enter: state=%0d solved=%b busy=%b want 5/1/1", state, solved, busy);
        end
        manual_req = 1'b1; manual_face = 3'd0; manual_rot = 2'b01;
        tick();
        manual_req = 1'b0;
        checks++;
        if ({state, drop} !== {3'd5, 1'b1}) begin
            errors++;
            $display("FAIL solved_manual_drop: state=%0d drop=%b want 5/1", state, drop);
        end
        undo_req = 1'b1;
        tick();
        undo_req = 1'b0;
        checks++;
        if ({state, drop, hist_pop} !== {3'd5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL solved_undo_drop: state=%0d drop=%b pop=%b want 5/1/0", state, drop, hist_pop);
        end
        scramble_req = 1'b1;
        tick();
        scramble_req = 1'b0;
        checks++;
        if ({state, solved, move_count, hist_ptr} !== {3'd2, 1'b0, 10'd0, 6'd0}) begin
            errors++;
            $display("FAIL solved_rescramble: state=%0d solved=%b mc=%0d hp=%0d want 2/0/0/0", state, solved, move_count, hist_ptr);
        end
        manual_req = 1'b1;
        tick();
        manual_req = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({state, cube_init, busy, cube_load, solved, move_count, hist_ptr, drop, hist_push, hist_pop}
            !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 6'd0, 3'b0}) begin
            errors++;
            $display("FAIL async_reset: state=%0d init=%b busy=%b load=%b solved=%b mc=%0d hp=%0d drop=%b want 0/1/1/0/0/0/0/0",
                     state, cube_init, busy, cube_load, solved, move_count, hist_ptr, drop);
        end
        @(negedge clk) rst = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            nl += int'(cube_load);
            tick();
        end
        checks++;
        if (nl != 0 || state !== 3'd1) begin
            errors++;
            $display("FAIL reset_flush: loads=%0d state=%0d want 0/1", nl, state);
        end
    endtask

    initial begin
        test_reset();
        test_manual_undo();
        test_scramble();
        test_same_cycle();
        test_queue_fill();
        test_solved_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
